hier_node_sequencer: RTL
========================

Name: hier_node_sequencer

Overview:
- Parametrised hierarchy node controller; it generalises the fixed five-child structural node into an active node with NUM_CHILD children.
- On one start request, it launches the enabled children and collects their completion.
- Two modes: parallel (all children at once) or serial (ascending index, one at a time).
- Instances cascade: a parent's child_start_o drives a child node's start_i, and the child's done_o returns as the parent's child_done_i.

Parameters:
- NUM_CHILD, 5, number of child channels (1..32).
- TIMEOUT_CYC, 255, per-wait timeout in cycles (only with the optional feature).
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = parallel, 1 = serial; latched at start.
- child_en_i  in  NUM_CHILD  enable mask; latched at start.
- child_done_i  in  NUM_CHILD  per-child completion pulse or level; rising level is captured.
- child_start_o  out  NUM_CHILD  one-cycle start pulse per child.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle completion pulse.
- done_mask_o  out  NUM_CHILD  children that completed; valid while done_o is high, held until next start.
- err_o  out  1  sticky timeout flag; cleared at next accepted start.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: FSM in IDLE; all outputs 0; latched mode, mask and capture registers 0. Reset asserted mid-operation aborts immediately; no further child_start_o pulses follow.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - start_i = 1 latches mode_i and child_en_i and clears the capture register and err_o. Next state is LAUNCH.
  - start_i while not in IDLE is ignored (no queueing).
- LAUNCH, parallel mode:
  - child_start_o = latched mask for exactly one cycle.
  - Next state is WAIT.
- LAUNCH, serial mode:
  - child_start_o = one-hot of the current index.
  - The current index is the lowest enabled index not yet captured.
  - Next state is WAIT.
- LAUNCH, empty mask: no pulses; go directly to FINISH.
- WAIT:
  - child_done_i is ANDed with the launched set and ORed into the capture register. Capture begins the cycle after the start pulse; done asserted during the LAUNCH cycle is not captured.
  - Parallel mode: when capture == mask, go to FINISH.
  - Serial mode: when the current child is captured, go to LAUNCH for the next enabled index, or to FINISH if none remain.
  - Done from a non-launched or already captured child is ignored.
- FINISH: done_o = 1 and done_mask_o = capture register for one cycle. busy_o falls in the same cycle. Next state is IDLE.
- Latency:
  - start_i at cycle 0 gives child_start_o at cycle 1.
  - Last done captured at cycle N gives done_o at cycle N+1.
  - Serial mode adds one cycle per hop (WAIT -> LAUNCH).
- Simultaneous events: start_i in the FINISH cycle is ignored; start_i is accepted again one cycle after done_o.

Optional Feature:
- Macro: HIER_SEQ_TIMEOUT_EN.
- With the macro:
  - A CNT_W-bit counter resets on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC sets err_o (sticky).
  - Parallel mode: go to FINISH, with done_mask_o showing only the completed children.
  - Serial mode: skip the stalled child and launch the next one.
  - A done arriving in the same cycle as the timeout counts as done, not as timeout.
- Without the macro: no counter; WAIT lasts indefinitely; err_o is tied to 0.

Test Plan:
- Parallel, NUM_CHILD = 5, mask 5'b11111, all dones at cycle 4 -> child_start_o = 5'b11111 at cycle 1 only; done_o at cycle 5; done_mask_o = 5'b11111; busy_o high cycles 1-4.
- Serial, mask 5'b10101, each child done 2 cycles after its start -> one-hot starts at indices 0, 2, 4 in order, never 1 or 3; exactly one done_o; done_mask_o = 5'b10101.
- Mask 5'b00000, start at cycle 0 -> no child_start_o; done_o at cycle 2; done_mask_o = 0.
- start_i re-pulsed while busy, plus a done from disabled child 1 -> no relaunch; child 1 is not captured; one done_o.
- Reset asserted in WAIT (serial, after child 0 done) -> all outputs 0 the next cycle; no further starts; a new start runs cleanly.
- HIER_SEQ_TIMEOUT_EN, TIMEOUT_CYC = 10, parallel mask 5'b00011, child 1 never done -> err_o = 1; done_o 11 cycles after WAIT entry; done_mask_o = 5'b00001. Same stimulus without the macro -> stays busy forever, err_o = 0.

Source files
------------

// File: rtl/hier_node_sequencer_if.sv
// Start/completion bundle between a hierarchy node sequencer and its parent:
// start/mode/enable requests in, child launch and completion status out.
interface hier_node_sequencer_if #(
  parameter int unsigned NUM_CHILD = 5
);
  logic                 start_i;
  logic                 mode_i;
  logic [NUM_CHILD-1:0] child_en_i;
  logic [NUM_CHILD-1:0] child_done_i;
  logic [NUM_CHILD-1:0] child_start_o;
  logic                 busy_o;
  logic                 done_o;
  logic [NUM_CHILD-1:0] done_mask_o;
  logic                 err_o;

  modport master (
    output start_i, mode_i, child_en_i, child_done_i,
    input  child_start_o, busy_o, done_o, done_mask_o, err_o
  );

  modport slave (
    input  start_i, mode_i, child_en_i, child_done_i,
    output child_start_o, busy_o, done_o, done_mask_o, err_o
  );
endinterface

// File: rtl/hier_node_sequencer.sv
// Hierarchy node controller: launches enabled children in parallel or serially
// and collects their completion. Optional per-wait timeout: HIER_SEQ_TIMEOUT_EN.
module hier_node_sequencer #(
  parameter int unsigned NUM_CHILD   = 5,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  hier_node_sequencer_if.slave   bus
);

  if (NUM_CHILD == 0 || NUM_CHILD > 32 ||
      64'(TIMEOUT_CYC) >= (64'(1) << CNT_W)) begin : g_bad_cfg
    $error("hier_node_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t               state_q;
  logic                 mode_q;
  logic [NUM_CHILD-1:0] mask_q;
  logic [NUM_CHILD-1:0] cap_q;
  logic [NUM_CHILD-1:0] launched_q;
  logic [NUM_CHILD-1:0] cur_q;
  logic [NUM_CHILD-1:0] start_q;
  logic [NUM_CHILD-1:0] done_mask_q;
  logic                 busy_q;
  logic                 done_q;

  logic [NUM_CHILD-1:0] cap_nxt;
  logic [NUM_CHILD-1:0] pend;
  logic [NUM_CHILD-1:0] next_hot;
  logic [NUM_CHILD-1:0] first_hot;
  logic                 cur_done;
  logic                 tmo;

  // Only dones from launched children count; x & -x isolates the lowest set bit.
  assign cap_nxt   = cap_q | (bus.child_done_i & launched_q);
  assign pend      = mask_q & ~launched_q;
  assign next_hot  = pend & (~pend + NUM_CHILD'(1));
  assign first_hot = bus.child_en_i & (~bus.child_en_i + NUM_CHILD'(1));
  assign cur_done  = mode_q ? |(cap_nxt & cur_q) : (cap_nxt == mask_q);

`ifdef HIER_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  assign tmo       = (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign bus.err_o = err_q;
`else
  assign tmo       = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  assign bus.child_start_o = start_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.done_mask_o   = done_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      mask_q      <= '0;
      cap_q       <= '0;
      launched_q  <= '0;
      cur_q       <= '0;
      start_q     <= '0;
      done_mask_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef HIER_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            mode_q      <= bus.mode_i;
            mask_q      <= bus.child_en_i;
            cap_q       <= '0;
            done_mask_q <= '0;
            busy_q      <= 1'b1;
            cur_q       <= first_hot;
            // Pulses are registered here so they appear in the LAUNCH cycle.
            start_q     <= bus.mode_i ? first_hot : bus.child_en_i;
            launched_q  <= bus.mode_i ? first_hot : bus.child_en_i;
`ifdef HIER_SEQ_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (launched_q == '0) begin
            done_q      <= 1'b1;
            done_mask_q <= cap_q;
            busy_q      <= 1'b0;
            state_q     <= FINISH;
          end else begin
`ifdef HIER_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
`endif
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          cap_q <= cap_nxt;
`ifdef HIER_SEQ_TIMEOUT_EN
          cnt_q <= cnt_q + CNT_W'(1);
          if (tmo && !cur_done) begin
            err_q <= 1'b1;
          end
`endif
          if (cur_done || tmo) begin
            if (mode_q && pend != '0) begin
              start_q    <= next_hot;
              launched_q <= launched_q | next_hot;
              cur_q      <= next_hot;
              state_q    <= LAUNCH;
            end else begin
              done_q      <= 1'b1;
              done_mask_q <= cap_nxt;
              busy_q      <= 1'b0;
              state_q     <= FINISH;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
